seg_scan_driver: RTL and testbench



---
 rtl/seg_scan_driver.sv | 122 ++++++++++++
 tb/tb_seg_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: multiplexed common-cathode 7-segment driver
// with a code buffer, a glyph decoder, scrolling and blanking.
module seg_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000,
  parameter int AW       = $clog2(DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [4:0]        wr_code,
  input  logic              scroll_en,
  input  logic              scroll_step,
  input  logic              blank,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] dig_sel
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [AW-1:0] IDX_MAX = AW'(DIGITS - 1);
  localparam logic [AW:0]   DIG_N   = (AW+1)'(DIGITS);

  logic [DW-1:0]     div_cnt;
  logic [AW-1:0]     scan_idx;
  logic [AW-1:0]     offset;
  logic [4:0]        code_q [DIGITS];

  logic              tc;
  logic [DW-1:0]     div_nxt;
  logic [AW-1:0]     scan_nxt;
  logic [AW-1:0]     off_nxt;
  logic [AW:0]       sum;
  logic [AW-1:0]     disp_idx;
  logic [DIGITS-1:0] sel_nxt;
  logic [6:0]        seg_nxt;
  logic              wr_ok;

  function automatic logic [6:0] glyph(input logic [4:0] c);
    logic [6:0] g;
    case (c)
      5'd0:    g = 7'b1100110;
      5'd1:    g = 7'b1110000;
      5'd2:    g = 7'b0011101;
      5'd3:    g = 7'b1110110;
      5'd4:    g = 7'b1110000;
      5'd5:    g = 7'b1000000;
      5'd6:    g = 7'b0111110;
      5'd7:    g = 7'b1001111;
      5'd8:    g = 7'b0011110;
      5'd9:    g = 7'b1111000;
      5'd10:   g = 7'b1111001;
      5'd11:   g = 7'b0110111;
      5'd12:   g = 7'b1000111;
      5'd13:   g = 7'b0000101;
      5'd14:   g = 7'b0000110;
      5'd15:   g = 7'b1011011;
      5'd16:   g = 7'b1110111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  // Next-state values; outputs are built from these so that
  // digit select and glyph always move together.
  always_comb begin
    tc       = (div_cnt == DIV_MAX);
    div_nxt  = tc ? '0 : div_cnt + 1'b1;
    scan_nxt = scan_idx;
    if (tc)
      scan_nxt = (scan_idx == IDX_MAX) ? '0 : scan_idx + 1'b1;
    off_nxt = offset;
    if (!scroll_en)
      off_nxt = '0;
    else if (scroll_step)
      off_nxt = (offset == IDX_MAX) ? '0 : offset + 1'b1;
    sum      = {1'b0, scan_nxt} + {1'b0, off_nxt};
    disp_idx = (sum >= DIG_N) ? AW'(sum - DIG_N) : sum[AW-1:0];
    sel_nxt  = DIGITS'(1) << scan_nxt;
    seg_nxt  = glyph(code_q[disp_idx]);
    wr_ok    = wr_en && ({1'b0, wr_addr} < DIG_N);
  end

  // Divider, scan position and scroll offset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      scan_idx <= '0;
      offset   <= '0;
    end else begin
      div_cnt  <= div_nxt;
      scan_idx <= scan_nxt;
      offset   <= off_nxt;
    end
  end

  // Code buffer; out-of-range addresses are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++)
        code_q[i] <= 5'd31;
    end else if (wr_ok) begin
      code_q[wr_addr] <= wr_code;
    end
  end

  // Registered pins, forced dark while blank is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg     <= '0;
      dig_sel <= DIGITS'(1);
    end else if (blank) begin
      seg     <= '0;
      dig_sel <= '0;
    end else begin
      seg     <= seg_nxt;
      dig_sel <= sel_nxt;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver
// (4 digits / div 3, plus a 3 digit / div 1 instance).
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [4:0] wr_code;
  logic       scroll_en;
  logic       scroll_step;
  logic       blank;
  logic [6:0] seg;
  logic [3:0] dig_sel;

  logic       wr_en2;
  logic [1:0] wr_addr2;
  logic [4:0] wr_code2;
  logic [6:0] seg2;
  logic [2:0] dig_sel2;

  int e;
  int nvec;
  int nbad;

  logic [6:0] g4 [4];
  logic [4:0] c4 [4];
  logic [6:0] g3 [3];
  logic [1:0] a3 [4];
  logic [4:0] c3 [4];

  always #5 clk = ~clk;

  seg_scan_driver #(.DIGITS(4), .SCAN_DIV(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_code    (wr_code),
    .scroll_en  (scroll_en),
    .scroll_step(scroll_step),
    .blank      (blank),
    .seg        (seg),
    .dig_sel    (dig_sel)
  );

  seg_scan_driver #(.DIGITS(3), .SCAN_DIV(1)) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en2),
    .wr_addr    (wr_addr2),
    .wr_code    (wr_code2),
    .scroll_en  (1'b0),
    .scroll_step(1'b0),
    .blank      (1'b0),
    .seg        (seg2),
    .dig_sel    (dig_sel2)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nbad++;
      $error("FAIL %s e=%0d got %b want %b",
             tag, e, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  function automatic logic [7:0] dexp();
    return 8'(1 << ((e / 3) % 4));
  endfunction

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    g4 = '{7'b1100110, 7'b0011101, 7'b1011011, 7'b1110111};
    c4 = '{5'd0, 5'd2, 5'd15, 5'd16};
    g3 = '{7'b1100110, 7'b1000000, 7'b1111000};
    a3 = '{2'd0, 2'd1, 2'd2, 2'd3};
    c3 = '{5'd0, 5'd5, 5'd9, 5'd16};
    e = 0; nvec = 0; nbad = 0;
    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_code = '0;
    scroll_en = 1'b0; scroll_step = 1'b0; blank = 1'b0;
    wr_en2 = 1'b0; wr_addr2 = '0; wr_code2 = '0;

    repeat (2) @(negedge clk);
    chk("rst_seg", {1'b0, seg}, 8'h00);
    chk("rst_dig", {4'b0, dig_sel}, 8'h01);
    rst_n = 1'b1;

    // first frame, empty buffer
    for (int n = 0; n < 12; n++) begin
      step();
      chk("frame_seg", {1'b0, seg}, 8'h00);
      chk("frame_dig", {4'b0, dig_sel}, dexp());
    end

    // load 0,2,15,16
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 2'(i); wr_code = c4[i];
      step();
    end
    wr_en = 1'b0;
    for (int n = 0; n < 11; n++) begin
      step();
      chk("dec_seg", {1'b0, seg}, {1'b0, g4[(e / 3) % 4]});
      chk("dec_dig", {4'b0, dig_sel}, dexp());
    end

    // write code 7 into live digit 1 at edge 28
    wr_en = 1'b1; wr_addr = 2'd1; wr_code = 5'd7;
    step();
    wr_en = 1'b0;
    chk("live_old", {1'b0, seg}, 8'b00011101);
    step();
    chk("live_new", {1'b0, seg}, 8'b01001111);
    chk("live_dig", {4'b0, dig_sel}, 8'b0010);
    wr_en = 1'b1; wr_addr = 2'd1; wr_code = 5'd2;
    step();
    wr_en = 1'b0;
    repeat (3) step();

    // scroll by one, step sampled at edge 34
    scroll_en = 1'b1; scroll_step = 1'b1;
    step();
    scroll_step = 1'b0;
    chk("scr_d3", {1'b0, seg}, 8'b01100110);
    chk("scr_d3s", {4'b0, dig_sel}, 8'b1000);
    repeat (2) step();
    chk("scr_d0", {1'b0, seg}, 8'b00011101);
    chk("scr_d0s", {4'b0, dig_sel}, 8'b0001);
    repeat (3) step();
    chk("scr_d1", {1'b0, seg}, 8'b01011011);
    repeat (3) step();
    chk("scr_d2", {1'b0, seg}, 8'b01110111);
    scroll_en = 1'b0;
    step();
    chk("unscr_d2", {1'b0, seg}, 8'b01011011);
    chk("unscr_d2s", {4'b0, dig_sel}, 8'b0100);
    repeat (2) step();
    chk("unscr_d3", {1'b0, seg}, 8'b01110111);
    repeat (3) step();
    chk("unscr_d0", {1'b0, seg}, 8'b01100110);

    // tc + scroll step + write to next shown entry at edge 51
    repeat (2) step();
    scroll_en = 1'b1; scroll_step = 1'b1;
    wr_en = 1'b1; wr_addr = 2'd2; wr_code = 5'd5;
    step();
    scroll_step = 1'b0; wr_en = 1'b0;
    chk("sim_dig", {4'b0, dig_sel}, 8'b0010);
    chk("sim_seg", {1'b0, seg}, 8'b01011011);
    step();
    chk("sim_wr", {1'b0, seg}, 8'b01000000);
    scroll_en = 1'b0;
    step();
    chk("sim_clr", {1'b0, seg}, 8'b00011101);
    chk("sim_clrs", {4'b0, dig_sel}, 8'b0010);

    // blank for 5 edges
    blank = 1'b1;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("blk_seg", {1'b0, seg}, 8'h00);
      chk("blk_dig", {4'b0, dig_sel}, 8'h00);
    end
    blank = 1'b0;
    step();
    chk("unblk_dig", {4'b0, dig_sel}, 8'b1000);
    chk("unblk_seg", {1'b0, seg}, 8'b01110111);

    // async reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("arst_seg", {1'b0, seg}, 8'h00);
    chk("arst_dig", {4'b0, dig_sel}, 8'h01);
    chk("arst_dig2", {5'b0, dig_sel2}, 8'h01);
    #1 rst_n = 1'b1;
    e = 0;

    // buffer reads blank; second instance loads and scans
    for (int n = 1; n <= 12; n++) begin
      wr_en2 = (n <= 4);
      wr_addr2 = a3[(n - 1) % 4];
      wr_code2 = c3[(n - 1) % 4];
      step();
      chk("post_seg", {1'b0, seg}, 8'h00);
      chk("post_dig", {4'b0, dig_sel}, dexp());
      if (n >= 5) begin
        chk("d1_seg", {1'b0, seg2}, {1'b0, g3[n % 3]});
        chk("d1_dig", {5'b0, dig_sel2}, 8'(1 << (n % 3)));
      end
    end
    wr_en2 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
